// File: rtl/instr_sequencer_pkg.sv
// Shared types for the instruction sequencer and its neighbours: register file
// port encodings, opcodes, FSM states and the ALU function select.
package instr_sequencer_pkg;

  localparam int DATA_BUS_WIDTH = 8;
  localparam int INSTR_WIDTH    = 8;

  typedef enum logic {
    REG_NOP   = 1'b0,
    REG_WRITE = 1'b1
  } registers_op_e;

  typedef enum logic [1:0] {
    REG_0 = 2'd0,
    REG_1 = 2'd1,
    REG_2 = 2'd2,
    REG_3 = 2'd3
  } register_sel_e;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_MOV   = 4'h1,
    OP_LDI   = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_XOR   = 4'h7,
    OP_LD    = 4'h8,
    OP_ST    = 4'h9,
    OP_JMP   = 4'hA,
    OP_JZ    = 4'hB,
    OP_RSV_C = 4'hC,
    OP_RSV_D = 4'hD,
    OP_RSV_E = 4'hE,
    OP_HLT   = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_IMM    = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } seq_state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_e;

  // Coarse grouping of opcodes by what the sequencer has to do with them.
  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_MOV     = 3'd1,
    CLS_ALU     = 3'd2,
    CLS_IMM     = 3'd3,
    CLS_MEM     = 3'd4,
    CLS_HALT    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_e;

  typedef struct packed {
    opcode_e       op;
    register_sel_e rd;
    register_sel_e rs;
  } instr_t;

endpackage

// File: rtl/instr_sequencer_decoder.sv
// Combinational instruction decoder: classifies the held instruction and
// selects the ALU function for the arithmetic/logic opcodes.
module instr_decoder
  import instr_sequencer_pkg::*;
(
  input  instr_t       ir,
  output instr_class_e instr_class,
  output alu_op_e      alu_op,
  output logic         needs_imm,
  output logic         is_mem,
  output logic         illegal
);

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    instr_class = CLS_ILLEGAL;
    alu_op      = ALU_ADD;
    needs_imm   = 1'b0;
    is_mem      = 1'b0;
    illegal     = 1'b0;
    case (ir.op)
      OP_NOP: instr_class = CLS_NOP;
      OP_MOV: instr_class = CLS_MOV;
      OP_LDI, OP_JMP, OP_JZ: begin
        instr_class = CLS_IMM;
        needs_imm   = 1'b1;
      end
      OP_ADD: begin instr_class = CLS_ALU; alu_op = ALU_ADD; end
      OP_SUB: begin instr_class = CLS_ALU; alu_op = ALU_SUB; end
      OP_AND: begin instr_class = CLS_ALU; alu_op = ALU_AND; end
      OP_OR:  begin instr_class = CLS_ALU; alu_op = ALU_OR;  end
      OP_XOR: begin instr_class = CLS_ALU; alu_op = ALU_XOR; end
      OP_LD, OP_ST: begin
        instr_class = CLS_MEM;
        is_mem      = 1'b1;
      end
      OP_HLT: instr_class = CLS_HALT;
      default: begin
        instr_class = CLS_ILLEGAL;
        illegal     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: fetches 8-bit instructions over a req/ready
// memory port and drives the 4-entry register file and ALU select.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = instr_sequencer_pkg::DATA_BUS_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [DATA_BUS_WIDTH-1:0] mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
  input  logic [DATA_BUS_WIDTH-1:0] mem_rdata,
  input  logic                      mem_ready,
  output registers_op_e             reg_op,
  output register_sel_e             reg_in_sel,
  output register_sel_e             reg_1_out_sel,
  output register_sel_e             reg_2_out_sel,
  output logic [DATA_BUS_WIDTH-1:0] reg_data_in,
  input  logic [DATA_BUS_WIDTH-1:0] reg_1_val,
  input  logic [DATA_BUS_WIDTH-1:0] reg_2_val,
  output alu_op_e                   alu_op,
  input  logic [DATA_BUS_WIDTH-1:0] alu_result,
  input  logic                      alu_zero,
  output logic [DATA_BUS_WIDTH-1:0] pc,
  output logic                      halted,
  output logic                      illegal
);

  localparam int W = DATA_BUS_WIDTH;

  seq_state_e   state, state_next;
  instr_t       ir, ir_next;
  logic [W-1:0] pc_next;
  logic [W-1:0] pc_inc;
  logic         zflag, zflag_next;

  instr_class_e dec_class;
  logic         dec_needs_imm;
  logic         dec_is_mem;
  logic         dec_illegal;

  instr_decoder u_decoder (
    .ir          (ir),
    .instr_class (dec_class),
    .alu_op      (alu_op),
    .needs_imm   (dec_needs_imm),
    .is_mem      (dec_is_mem),
    .illegal     (dec_illegal)
  );

  // Modulo 2^W: 0xFF wraps to 0x00 for both fetch and immediate reads.
  assign pc_inc = pc + W'(1);

  assign reg_in_sel    = ir.rd;
  assign reg_1_out_sel = ir.rd;
  assign reg_2_out_sel = ir.rs;

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
      zflag <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
      zflag <= zflag_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    ir_next     = ir;
    zflag_next  = zflag;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = pc;
    mem_wdata   = '0;
    reg_op      = REG_NOP;
    reg_data_in = '0;
    halted      = 1'b0;
    illegal     = 1'b0;

    case (state)
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) begin
          ir_next    = instr_t'(mem_rdata[INSTR_WIDTH-1:0]);
          pc_next    = pc_inc;
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        state_next = ST_FETCH;
        if (dec_needs_imm) begin
          state_next = ST_IMM;
        end else if (dec_is_mem) begin
          state_next = ST_MEM;
        end else if (dec_illegal) begin
          illegal = 1'b1;
        end else begin
          case (dec_class)
            CLS_MOV: begin
              reg_op      = REG_WRITE;
              reg_data_in = reg_2_val;
            end
            CLS_ALU: begin
              reg_op      = REG_WRITE;
              reg_data_in = alu_result;
              zflag_next  = alu_zero;
            end
            CLS_HALT: state_next = ST_HALT;
            default:  state_next = ST_FETCH;
          endcase
        end
      end

      ST_IMM: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) begin
          pc_next    = pc_inc;
          state_next = ST_FETCH;
          case (ir.op)
            OP_LDI: begin
              reg_op      = REG_WRITE;
              reg_data_in = mem_rdata;
            end
            OP_JMP: pc_next = mem_rdata;
            OP_JZ:  if (zflag) pc_next = mem_rdata;
            default: pc_next = pc_inc;
          endcase
        end
      end

      ST_MEM: begin
        mem_req   = 1'b1;
        mem_addr  = reg_2_val;
        mem_we    = (ir.op == OP_ST);
        mem_wdata = reg_1_val;
        if (mem_ready) begin
          state_next = ST_FETCH;
          if (ir.op == OP_LD) begin
            reg_op      = REG_WRITE;
            reg_data_in = mem_rdata;
          end
        end
      end

      ST_HALT: halted = 1'b1;

      default: state_next = ST_FETCH;
    endcase

    // Reset is synchronous, so the state register may still hold a mid-access
    // state while reset is low; suppress every side-effecting output here.
    if (!reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      reg_op  = REG_NOP;
      halted  = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a memory responder (programmable wait
// states), a 4-entry register file model and an ALU model around the DUT.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int W = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mem_req, mem_we, mem_ready;
  logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;
  registers_op_e reg_op;
  register_sel_e reg_in_sel, reg_1_out_sel, reg_2_out_sel;
  logic [W-1:0]  reg_data_in, reg_1_val, reg_2_val;
  alu_op_e       alu_op;
  logic [W-1:0]  alu_result;
  logic          alu_zero;
  logic [W-1:0]  pc;
  logic          halted, illegal;

  logic [W-1:0] mem [256];
  logic [W-1:0] rf  [4];
  int           n_total = 0;
  int           n_bad   = 0;
  int           reg_writes = 0;
  int           store_cnt  = 0;
  int           rd_wait = 0;
  int           st_wait = 0;
  int           wait_cnt = 0;
  int           need;
  int           base_writes;
  int           base_stores;
  logic [W-1:0] last_st_addr = '0;
  logic [W-1:0] last_st_data = '0;

  instr_sequencer #(.DATA_BUS_WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .reg_op        (reg_op),
    .reg_in_sel    (reg_in_sel),
    .reg_1_out_sel (reg_1_out_sel),
    .reg_2_out_sel (reg_2_out_sel),
    .reg_data_in   (reg_data_in),
    .reg_1_val     (reg_1_val),
    .reg_2_val     (reg_2_val),
    .alu_op        (alu_op),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .pc            (pc),
    .halted        (halted),
    .illegal       (illegal)
  );

  always #5 clock = ~clock;

  assign reg_1_val = rf[reg_1_out_sel];
  assign reg_2_val = rf[reg_2_out_sel];

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = reg_1_val + reg_2_val;
      ALU_SUB: alu_result = reg_1_val - reg_2_val;
      ALU_AND: alu_result = reg_1_val & reg_2_val;
      ALU_OR:  alu_result = reg_1_val | reg_2_val;
      ALU_XOR: alu_result = reg_1_val ^ reg_2_val;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (reg_op == REG_WRITE) begin
      rf[reg_in_sel] <= reg_data_in;
      reg_writes     <= reg_writes + 1;
    end
  end

  // Memory responder: decides mem_ready on the falling edge for the next rising edge.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      need = mem_we ? st_wait : rd_wait;
      if (reset && mem_req) begin
        if (wait_cnt >= need) begin
          mem_ready = 1'b1;
          mem_rdata = mem_we ? '0 : mem[mem_addr];
          wait_cnt  = 0;
          if (mem_we) begin
            store_cnt    = store_cnt + 1;
            last_st_addr = mem_addr;
            last_st_data = mem_wdata;
          end
        end else begin
          mem_ready = 1'b0;
          wait_cnt  = wait_cnt + 1;
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold reset for two edges and blank memory with HLT so stray fetches stop.
  task automatic enter_reset();
    reset = 1'b0;
    rd_wait = 0;
    st_wait = 0;
    for (int a = 0; a < 256; a++) mem[a] = 8'hF0;
    tick(2);
  endtask

  task automatic leave_reset();
    reset = 1'b1;
    base_writes = reg_writes;
    base_stores = store_cnt;
  endtask

  initial begin
    // Reset values
    tick(2);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_reg_op", reg_op, REG_NOP);
    check("rst_pc", pc, 0);
    check("rst_in_sel", reg_in_sel, 0);
    check("rst_2_sel", reg_2_out_sel, 0);

    // LDI r1,05; LDI r2,03; ADD r1,r2
    enter_reset();
    mem[0] = 8'h24; mem[1] = 8'h05; mem[2] = 8'h28; mem[3] = 8'h03; mem[4] = 8'h36;
    leave_reset();
    #1;
    check("fetch0_req", mem_req, 1);
    check("fetch0_addr", mem_addr, 8'h00);
    check("fetch0_we", mem_we, 0);
    tick(8);
    check("add_pc", pc, 8'h05);
    check("add_r1", rf[1], 8'h08);
    check("add_r2", rf[2], 8'h03);
    check("add_writes", reg_writes - base_writes, 3);

    // LDI r1,07; SUB r1,r1; JZ 40 -> taken
    enter_reset();
    mem[0] = 8'h24; mem[1] = 8'h07; mem[2] = 8'h45; mem[3] = 8'hB0; mem[4] = 8'h40;
    leave_reset();
    tick(8);
    check("jz_taken_pc", pc, 8'h40);
    check("jz_taken_r1", rf[1], 8'h00);

    // LDI r1,07; LDI r2,02; SUB r1,r2; JZ 40 -> not taken
    enter_reset();
    mem[0] = 8'h24; mem[1] = 8'h07; mem[2] = 8'h28; mem[3] = 8'h02;
    mem[4] = 8'h46; mem[5] = 8'hB0; mem[6] = 8'h40;
    leave_reset();
    tick(11);
    check("jz_nt_pc", pc, 8'h07);
    check("jz_nt_r1", rf[1], 8'h05);

    // LDI r2,3C; MOV r0,r2; LDI r1,FF; XOR r1,r2
    enter_reset();
    mem[0] = 8'h28; mem[1] = 8'h3C; mem[2] = 8'h12; mem[3] = 8'h24; mem[4] = 8'hFF; mem[5] = 8'h76;
    leave_reset();
    tick(10);
    check("mov_r0", rf[0], 8'h3C);
    check("xor_r1", rf[1], 8'hC3);
    check("movxor_pc", pc, 8'h06);

    // LDI r0,80; LDI r3,A5; ST r3->[r0] with 3 wait states; HLT
    enter_reset();
    mem[0] = 8'h20; mem[1] = 8'h80; mem[2] = 8'h2C; mem[3] = 8'hA5; mem[4] = 8'h9C;
    st_wait = 3;
    leave_reset();
    tick(8);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("st_req_%0d", i), mem_req, 1);
      check($sformatf("st_we_%0d", i), mem_we, 1);
      check($sformatf("st_addr_%0d", i), mem_addr, 8'h80);
      check($sformatf("st_wdata_%0d", i), mem_wdata, 8'hA5);
      check($sformatf("st_pending_%0d", i), store_cnt - base_stores, 0);
      tick(1);
    end
    check("st_count", store_cnt - base_stores, 1);
    check("st_log_addr", last_st_addr, 8'h80);
    check("st_log_data", last_st_data, 8'hA5);
    check("st_after_we", mem_we, 0);
    check("st_reg_writes", reg_writes - base_writes, 2);
    tick(3);
    check("st_hlt_halted", halted, 1);
    check("st_hlt_req", mem_req, 0);
    tick(5);
    check("st_hlt_stores", store_cnt - base_stores, 1);
    check("st_hlt_req_late", mem_req, 0);

    // JMP FF; LDI at FF reads its immediate from 00
    enter_reset();
    mem[0] = 8'hA0; mem[1] = 8'hFF; mem[255] = 8'h2C;
    leave_reset();
    tick(3);
    check("wrap_pc_ff", pc, 8'hFF);
    check("wrap_fetch_addr", mem_addr, 8'hFF);
    tick(2);
    check("wrap_imm_addr", mem_addr, 8'h00);
    check("wrap_imm_req", mem_req, 1);
    tick(1);
    check("wrap_pc_01", pc, 8'h01);
    check("wrap_r3", rf[3], 8'hA0);

    // Reset during a stalled LD
    enter_reset();
    mem[0] = 8'h20; mem[1] = 8'h30; mem[2] = 8'h84; mem[8'h30] = 8'h77;
    leave_reset();
    tick(5);
    rd_wait = 10;
    check("ld_req", mem_req, 1);
    check("ld_addr", mem_addr, 8'h30);
    check("ld_we", mem_we, 0);
    tick(2);
    check("ld_still_waiting", mem_req, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_reg_op", reg_op, REG_NOP);
    tick(1);
    check("mid_rst_pc", pc, 8'h00);
    check("mid_rst_req2", mem_req, 0);
    reset = 1'b1;
    rd_wait = 0;
    #1;
    check("post_rst_req", mem_req, 1);
    check("post_rst_addr", mem_addr, 8'h00);
    check("post_rst_we", mem_we, 0);
    check("mid_rst_writes", reg_writes - base_writes, 1);

    // Illegal opcode C0, then HLT
    enter_reset();
    mem[0] = 8'hC0;
    leave_reset();
    tick(1);
    check("ill_pulse", illegal, 1);
    check("ill_reg_op", reg_op, REG_NOP);
    check("ill_req", mem_req, 0);
    tick(1);
    check("ill_pulse_end", illegal, 0);
    check("ill_next_addr", mem_addr, 8'h01);
    tick(2);
    check("hlt_halted", halted, 1);
    check("hlt_req", mem_req, 0);
    tick(5);
    check("hlt_halted_late", halted, 1);
    check("hlt_req_late", mem_req, 0);
    check("ill_writes", reg_writes - base_writes, 0);
    check("ill_stores", store_cnt - base_stores, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
